mario_sprite_ctrl: RTL and testbench
====================================

# mario_sprite_ctrl

Per-pixel sprite fetch scheduler that drives the colour mapper's `mario` select and `mario_pic_out` pixel inputs. It hit-tests the VGA scan position against the sprite bounding box and issues reads to the synchronous sprite ROM. It realigns the returned pixel, transparency-keyed, with a delayed copy of the sync signals. Position, facing and walk state come from game logic through a req/ack handshake and are applied only at frame boundaries, so the sprite never tears mid-frame.

## Interface

Parameters:
- SPRITE_W, 16, sprite width in pixels (power of 2)
- SPRITE_H, 32, sprite height in pixels (power of 2)
- FRAMES, 4, animation frames stored in ROM (frame 0 = standing; 1..FRAMES-1 = walk cycle)
- ADDR_W, 11, ROM address width (≥ log2(SPRITE_W·SPRITE_H·FRAMES))
- MEM_LAT, 2, ROM read latency in clocks (≥1)
- KEY_COLOR, 24'hFF00FF, transparent colour
- ANIM_DIV, 8, frames per walk-animation step (≥1)

Ports:
- Clk  in  1  system clock, all logic rising-edge
- Reset_n  in  1  asynchronous, active-low reset
- DrawX, DrawY  in  10 each  current scan position
- pix_valid  in  1  scan position is a real pixel this cycle
- sync_in  in  3  {hs, vs, blank} aligned with DrawX/DrawY
- frame_start  in  1  one-cycle pulse at start of vertical blank
- pos_x, pos_y  in  10 each  requested sprite top-left
- facing_left  in  1  requested horizontal mirror
- walking  in  1  requested walk animation enable
- upd_req  in  1  update request; pos/facing/walking stable while high
- upd_ack  out  1  one-cycle acknowledge
- mem_addr  out  ADDR_W  ROM address
- mem_rd  out  1  ROM read strobe
- mem_data  in  24  ROM data, MEM_LAT clocks after mem_addr/mem_rd
- mario  out  1  opaque sprite pixel present
- mario_pic_out  out  24  sprite RGB {R,G,B}
- sync_out  out  3  sync_in delayed to align with mario/mario_pic_out

## Operation

- Registers: pending {x,y,facing,walking,valid}; active {x,y,facing,walking}; anim index; divider count.
- Handshake: cycle with upd_req=1 and upd_ack=0 → capture inputs into pending, set pending.valid, upd_ack=1 the next cycle. upd_ack is never high two consecutive cycles. Holding req high yields one ack per two cycles. Requester drops req the cycle after seeing ack.
- A second capture before frame_start overwrites pending; last one wins.
- frame_start: if pending.valid, pending → active and pending.valid cleared. Anim update then uses the new active walking.
- frame_start with a simultaneous capture: the old pending is applied; the new capture goes to pending for the next frame_start.
- Anim when walking=0: index=0, divider=0.
- Anim when walking=1: divider increments per frame_start. When it reaches ANIM_DIV-1 it clears and the index advances. Index 0 → 1; FRAMES-1 wraps to 1.
- Hit test, 11-bit unsigned, no wrap:
  - x hit: pos_x ≤ DrawX < pos_x+SPRITE_W
  - y hit: pos_y ≤ DrawY < pos_y+SPRITE_H
  - Sprites past the right or bottom edge are clipped, not wrapped.
- lx=DrawX−pos_x; ly=DrawY−pos_y; col = facing ? SPRITE_W−1−lx : lx.
- mem_addr = anim·SPRITE_W·SPRITE_H + ly·SPRITE_W + col.
- mem_rd = pix_valid & hit. mem_addr holds its last value when mem_rd=0.
- Output: mario = hit_delayed & (mem_data ≠ KEY_COLOR). mario_pic_out = mem_data when hit_delayed, else 24'h0.

## Timing

- DrawX/DrawY sampled at edge t:
  - mem_addr/mem_rd registered at t+1
  - mem_data valid at t+1+MEM_LAT
  - mario/mario_pic_out registered at t+2+MEM_LAT
- Pipeline latency L = MEM_LAT+2. sync_out = sync_in delayed exactly L clocks.
- Fully pipelined: one pixel per clock, no stalls. pix_valid=0 injects a non-hit bubble.
- Active registers change only on the frame_start edge. A pixel sampled in the same cycle as frame_start uses the old values.
- upd_ack: 1 clock after capture.
- Reset (async assert, any time, including mid-frame or mid-handshake):
  - mario=0, mario_pic_out=0, mem_rd=0, mem_addr=0, upd_ack=0, sync_out=0
  - active/pending all 0, pending.valid=0, anim=0, divider=0
  - all pipeline hit bits cleared
- First output after reset release reflects pixels sampled after release.

## Test plan

- Reset, then upd_req with pos=(100,50), facing=0 and one frame_start; scan (100,50) → mem_addr=0 at t+1, mario=1 with ROM data at t+4 (MEM_LAT=2). Scan (116,50) and (99,50) → mem_rd=0, mario=0.
- ROM word at addr 5 = 24'hFF00FF; scan (105,50) → mario=0, mario_pic_out=24'hFF00FF. Word 24'h123456 → mario=1, pic=24'h123456.
- facing_left=1 applied at frame_start; scan (100,50) → mem_addr=15. Scan (115,81) → mem_addr=31·16+0=496.
- upd_req pos=(200,10) mid-frame → upd_ack the next clock. Pixels stay at the old position until frame_start, new position from the following cycle. Two requests before frame_start → only the second is applied.
- walking=1, ANIM_DIV=8 → anim sequence 1,1..(8 frames),2,3,1. mem_addr base steps by 512. walking=0 → anim=0 at the next frame_start.
- pos=(630,470); scan (639,479) → hit, mem_addr=9·16+9=153; no hit at x=0 or y=0. Reset_n pulsed low mid-line → all outputs 0 immediately; sync_out=0 until L clocks after release.

Source files
------------

// File: rtl/mario_sprite_ctrl_if.sv
// Game-logic to sprite-controller update channel: requested sprite state
// plus a req/ack handshake.
`timescale 1ns/1ps
interface mario_sprite_ctrl_if;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic       facing_left;
  logic       walking;
  logic       upd_req;
  logic       upd_ack;

  modport master (
    output pos_x, pos_y, facing_left, walking, upd_req,
    input  upd_ack
  );

  modport slave (
    input  pos_x, pos_y, facing_left, walking, upd_req,
    output upd_ack
  );
endinterface

// File: rtl/mario_sprite_ctrl.sv
// Per-pixel sprite fetch scheduler: hit-tests the scan position, reads the
// sprite ROM and realigns the keyed pixel with a delayed copy of sync.
`timescale 1ns/1ps
module mario_sprite_ctrl #(
  parameter int unsigned SPRITE_W  = 16,
  parameter int unsigned SPRITE_H  = 32,
  parameter int unsigned FRAMES    = 4,
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned MEM_LAT   = 2,
  parameter logic [23:0] KEY_COLOR = 24'hFF00FF,
  parameter int unsigned ANIM_DIV  = 8
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              pix_valid,
  input  logic [2:0]        sync_in,
  input  logic              frame_start,
  mario_sprite_ctrl_if.slave upd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [23:0]       mem_data,
  output logic              mario,
  output logic [23:0]       mario_pic_out,
  output logic [2:0]        sync_out
);
  localparam int unsigned LAT = MEM_LAT + 2;
  localparam int unsigned LXW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int unsigned LYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam int unsigned AW  = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int unsigned DW  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic [9:0]        r_pend_x, r_pend_y;
  logic              r_pend_face, r_pend_walk, r_pend_vld;
  logic [9:0]        r_act_x, r_act_y;
  logic              r_act_face, r_act_walk;
  logic [AW-1:0]     r_anim;
  logic [DW-1:0]     r_div;
  logic              r_ack;
  logic [MEM_LAT:0]  r_hit;
  logic [2:0]        r_sync [LAT];

  logic              w_cap;
  logic              w_walk_next;
  logic [10:0]       w_x, w_y, w_x0, w_y0;
  logic              w_hit;
  logic [LXW-1:0]    w_lx, w_col;
  logic [LYW-1:0]    w_ly;
  logic [ADDR_W-1:0] w_addr;

  assign w_cap       = upd.upd_req & ~r_ack;
  assign upd.upd_ack = r_ack;
  // Anim update on frame_start must see the walking value being applied now.
  assign w_walk_next = r_pend_vld ? r_pend_walk : r_act_walk;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ack       <= 1'b0;
      r_pend_x    <= '0;
      r_pend_y    <= '0;
      r_pend_face <= 1'b0;
      r_pend_walk <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_act_x     <= '0;
      r_act_y     <= '0;
      r_act_face  <= 1'b0;
      r_act_walk  <= 1'b0;
      r_anim      <= '0;
      r_div       <= '0;
    end else begin
      r_ack <= w_cap;
      if (frame_start && r_pend_vld) begin
        r_act_x    <= r_pend_x;
        r_act_y    <= r_pend_y;
        r_act_face <= r_pend_face;
        r_act_walk <= r_pend_walk;
      end
      // A capture coinciding with frame_start lands in pending for next frame.
      if (w_cap) begin
        r_pend_x    <= upd.pos_x;
        r_pend_y    <= upd.pos_y;
        r_pend_face <= upd.facing_left;
        r_pend_walk <= upd.walking;
        r_pend_vld  <= 1'b1;
      end else if (frame_start) begin
        r_pend_vld  <= 1'b0;
      end
      if (frame_start) begin
        if (!w_walk_next) begin
          r_anim <= '0;
          r_div  <= '0;
        end else if (r_div == DW'(ANIM_DIV - 1)) begin
          r_div  <= '0;
          r_anim <= (r_anim == AW'(FRAMES - 1)) ? AW'(1) : r_anim + AW'(1);
        end else begin
          r_div  <= r_div + DW'(1);
        end
      end
    end
  end

  // 11-bit compare so sprites near the right/bottom edge clip instead of wrap.
  assign w_x   = {1'b0, DrawX};
  assign w_y   = {1'b0, DrawY};
  assign w_x0  = {1'b0, r_act_x};
  assign w_y0  = {1'b0, r_act_y};
  assign w_hit = pix_valid
               && (w_x >= w_x0) && (w_x < w_x0 + 11'(SPRITE_W))
               && (w_y >= w_y0) && (w_y < w_y0 + 11'(SPRITE_H));

  assign w_lx   = LXW'(DrawX - r_act_x);
  assign w_ly   = LYW'(DrawY - r_act_y);
  assign w_col  = r_act_face ? ~w_lx : w_lx;
  assign w_addr = ADDR_W'(r_anim) * ADDR_W'(SPRITE_W * SPRITE_H)
                + ADDR_W'({w_ly, w_col});

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mem_rd        <= 1'b0;
      mem_addr      <= '0;
      r_hit         <= '0;
      mario         <= 1'b0;
      mario_pic_out <= '0;
      for (int unsigned i = 0; i < LAT; i++) r_sync[i] <= '0;
    end else begin
      mem_rd <= w_hit;
      if (w_hit) mem_addr <= w_addr;
      r_hit  <= {r_hit[MEM_LAT-1:0], w_hit};
      mario         <= r_hit[MEM_LAT] && (mem_data != KEY_COLOR);
      mario_pic_out <= r_hit[MEM_LAT] ? mem_data : '0;
      r_sync[0] <= sync_in;
      for (int unsigned i = 1; i < LAT; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign sync_out = r_sync[LAT-1];
endmodule

// File: tb/tb_mario_sprite_ctrl.sv
// Self-checking bench for mario_sprite_ctrl: directed scenarios plus random
// traffic checked against a per-cycle behavioural model of the sprite rules.
`timescale 1ns/1ps
module tb_mario_sprite_ctrl;
  localparam int SW = 16, SH = 32, FR = 4, AWD = 11, ML = 2, AD = 8;
  localparam logic [23:0] KEY = 24'hFF00FF;
  localparam int L  = ML + 2;
  localparam int D  = L - 1;
  localparam int NC = 8192;

  logic Clk = 1'b0;
  logic Reset_n;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic pix_valid = 1'b0, frame_start = 1'b0;
  logic [2:0] sync_in = '0;
  logic [AWD-1:0] mem_addr;
  logic mem_rd, mario;
  logic [23:0] mem_data, mario_pic_out;
  logic [2:0] sync_out;

  mario_sprite_ctrl_if upd();

  mario_sprite_ctrl #(
    .SPRITE_W(SW), .SPRITE_H(SH), .FRAMES(FR), .ADDR_W(AWD),
    .MEM_LAT(ML), .KEY_COLOR(KEY), .ANIM_DIV(AD)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .pix_valid(pix_valid), .sync_in(sync_in), .frame_start(frame_start),
    .upd(upd), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .mario(mario), .mario_pic_out(mario_pic_out), .sync_out(sync_out)
  );

  always #5 Clk = ~Clk;

  // Synchronous ROM with ML clocks of latency.
  logic [23:0] rom [2048];
  logic [23:0] rom_q [ML];
  always @(posedge Clk) begin
    rom_q[0] <= rom[mem_addr];
    for (int i = 1; i < ML; i++) rom_q[i] <= rom_q[i-1];
  end
  assign mem_data = rom_q[ML-1];

  // Reference model state
  int m_ax, m_ay, m_px, m_py, m_walkn, m_last;
  bit m_af, m_aw, m_pf, m_pw, m_pv, m_ack;
  bit        e_ack [NC], e_rd [NC], e_mario [NC];
  bit [10:0] e_addr [NC];
  bit [23:0] e_pic [NC];
  bit [2:0]  e_sync [NC];
  logic [40:0] a_obs [NC];
  int cyc = 0;
  int n_chk = 0, n_pass = 0;

  function automatic int m_anim();
    int steps;
    steps = m_walkn / AD;
    return (steps == 0) ? 0 : ((steps - 1) % (FR - 1)) + 1;
  endfunction

  function automatic logic [40:0] cur_obs();
    return {upd.upd_ack, mem_rd, mem_addr, mario, mario_pic_out, sync_out};
  endfunction

  function automatic logic [40:0] pack_exp(int n);
    return {e_ack[n], e_rd[n], e_addr[n], e_mario[n], e_pic[n], e_sync[n]};
  endfunction

  // One clock: model the edge, then sample the DUT 1ns later.
  task automatic tick();
    int n, x, y, a;
    bit h, cap;
    logic [23:0] d;
    sync_in = 3'($urandom);
    @(posedge Clk);
    cyc++;
    n = cyc;
    if (Reset_n) begin
      x = DrawX;
      y = DrawY;
      h = pix_valid && x >= m_ax && x < m_ax + SW && y >= m_ay && y < m_ay + SH;
      a = m_anim() * SW * SH + (y - m_ay) * SW + (m_af ? SW - 1 - (x - m_ax) : x - m_ax);
      if (h) begin
        d = rom[a];
        m_last = a;
      end else d = 24'h0;
      e_rd[n]      = h;
      e_addr[n]    = 11'(m_last);
      e_mario[n+D] = h && (d != KEY);
      e_pic[n+D]   = d;
      e_sync[n+D]  = sync_in;
      cap = upd.upd_req && !m_ack;
      if (frame_start) begin
        if (m_pv) begin
          m_ax = m_px; m_ay = m_py; m_af = m_pf; m_aw = m_pw; m_pv = 0;
        end
        m_walkn = m_aw ? m_walkn + 1 : 0;
      end
      if (cap) begin
        m_px = upd.pos_x; m_py = upd.pos_y; m_pf = upd.facing_left; m_pw = upd.walking; m_pv = 1;
      end
      m_ack    = cap;
      e_ack[n] = cap;
    end else begin
      e_rd[n] = 0; e_addr[n] = 0; e_ack[n] = 0;
      e_mario[n+D] = 0; e_pic[n+D] = 0; e_sync[n+D] = 0;
    end
    #1;
    a_obs[n] = cur_obs();
  endtask

  task automatic scan(input int x, input int y);
    DrawX = 10'(x); DrawY = 10'(y); pix_valid = 1'b1;
    tick();
  endtask

  task automatic idle(input int k);
    pix_valid = 1'b0;
    repeat (k) tick();
  endtask

  task automatic frame();
    pix_valid = 1'b0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic do_update(input int x, input int y, input bit f, input bit w);
    upd.pos_x = 10'(x); upd.pos_y = 10'(y); upd.facing_left = f; upd.walking = w;
    upd.upd_req = 1'b1; pix_valid = 1'b0;
    tick();
    upd.upd_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    int s;
    Reset_n = 1'b1;
    #2 Reset_n = 1'b0;
    #1;
    n_chk++;
    if (cur_obs() !== '0) $display("FAIL reset_outputs got=%h exp=0", cur_obs());
    else n_pass++;
    s = cyc + 1;
    repeat (3) tick();
    Reset_n = 1'b1;
    idle(L + 2);
    for (int n = s; n <= cyc; n++) begin
      n_chk++;
      if (a_obs[n] !== pack_exp(n)) $display("FAIL reset_sb cyc=%0d got=%h exp=%h", n, a_obs[n], pack_exp(n));
      else n_pass++;
    end
  endtask

  task automatic test_basic_hit();
    int s, n5, n6;
    s = cyc + 1;
    do_update(100, 50, 0, 0);
    frame();
    scan(100, 50);
    n_chk++;
    if ({mem_rd, mem_addr} !== {1'b1, 11'd0}) $display("FAIL basic_addr got=%b/%0d exp=1/0", mem_rd, mem_addr);
    else n_pass++;
    scan(116, 50);
    n_chk++;
    if ({mem_rd, mem_addr} !== {1'b0, 11'd0}) $display("FAIL right_miss_hold got=%b/%0d exp=0/0", mem_rd, mem_addr);
    else n_pass++;
    scan(99, 50);
    n_chk++;
    if (mem_rd !== 1'b0) $display("FAIL left_miss got=%b exp=0", mem_rd);
    else n_pass++;
    scan(105, 50); n5 = cyc;
    scan(106, 50); n6 = cyc;
    for (int x = 96; x < 120; x++) scan(x, 50 + (x % 3));
    idle(D + 1);
    n_chk++;
    if (a_obs[n5+D][27:3] !== {1'b0, KEY}) $display("FAIL key_transparent got=%h exp=%h", a_obs[n5+D][27:3], {1'b0, KEY});
    else n_pass++;
    n_chk++;
    if (a_obs[n6+D][27:3] !== {1'b1, 24'h123456}) $display("FAIL opaque_pixel got=%h exp=%h", a_obs[n6+D][27:3], {1'b1, 24'h123456});
    else n_pass++;
    for (int n = s; n <= cyc; n++) begin
      n_chk++;
      if (a_obs[n] !== pack_exp(n)) $display("FAIL basic_sb cyc=%0d got=%h exp=%h", n, a_obs[n], pack_exp(n));
      else n_pass++;
    end
  endtask

  task automatic test_facing();
    int s;
    s = cyc + 1;
    do_update(100, 50, 1, 0);
    frame();
    scan(100, 50);
    n_chk++;
    if (mem_addr !== 11'd15) $display("FAIL facing_addr got=%0d exp=15", mem_addr);
    else n_pass++;
    scan(115, 81);
    n_chk++;
    if (mem_addr !== 11'd496) $display("FAIL facing_corner got=%0d exp=496", mem_addr);
    else n_pass++;
    for (int i = 0; i < 40; i++) scan(96 + $urandom_range(0, 23), 46 + $urandom_range(0, 39));
    idle(D);
    for (int n = s; n <= cyc; n++) begin
      n_chk++;
      if (a_obs[n] !== pack_exp(n)) $display("FAIL facing_sb cyc=%0d got=%h exp=%h", n, a_obs[n], pack_exp(n));
      else n_pass++;
    end
  endtask

  task automatic test_update_timing();
    int s;
    bit exp_b;
    s = cyc + 1;
    upd.pos_x = 10'd200; upd.pos_y = 10'd10; upd.facing_left = 1'b0; upd.walking = 1'b0;
    upd.upd_req = 1'b1;
    scan(100, 50);
    n_chk++;
    if (upd.upd_ack !== 1'b1) $display("FAIL ack_next got=%b exp=1", upd.upd_ack);
    else n_pass++;
    upd.upd_req = 1'b0;
    scan(100, 50);
    n_chk++;
    if ({upd.upd_ack, mem_rd} !== 2'b01) $display("FAIL old_pos_kept got=%b exp=01", {upd.upd_ack, mem_rd});
    else n_pass++;
    scan(200, 10);
    n_chk++;
    if (mem_rd !== 1'b0) $display("FAIL new_pos_early got=%b exp=0", mem_rd);
    else n_pass++;
    do_update(300, 20, 0, 0);
    DrawX = 10'd100; DrawY = 10'd50; pix_valid = 1'b1; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_chk++;
    if (mem_rd !== 1'b1) $display("FAIL fs_cycle_old got=%b exp=1", mem_rd);
    else n_pass++;
    scan(300, 20);
    n_chk++;
    if ({mem_rd, mem_addr} !== {1'b1, 11'd0}) $display("FAIL last_req_wins got=%b/%0d exp=1/0", mem_rd, mem_addr);
    else n_pass++;
    scan(200, 10);
    n_chk++;
    if (mem_rd !== 1'b0) $display("FAIL first_req_dropped got=%b exp=0", mem_rd);
    else n_pass++;
    upd.pos_x = 10'd50; upd.pos_y = 10'd60; upd.upd_req = 1'b1;
    pix_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_b = (i % 2 == 0);
      n_chk++;
      if (upd.upd_ack !== exp_b) $display("FAIL ack_hold i=%0d got=%b exp=%b", i, upd.upd_ack, exp_b);
      else n_pass++;
    end
    upd.pos_x = 10'd400; upd.pos_y = 10'd100; frame_start = 1'b1;
    tick();
    frame_start = 1'b0; upd.upd_req = 1'b0;
    scan(50, 60);
    n_chk++;
    if (mem_rd !== 1'b1) $display("FAIL fs_old_pending got=%b exp=1", mem_rd);
    else n_pass++;
    frame();
    scan(400, 100);
    n_chk++;
    if ({mem_rd, mem_addr} !== {1'b1, 11'd0}) $display("FAIL fs_capture_deferred got=%b/%0d exp=1/0", mem_rd, mem_addr);
    else n_pass++;
    idle(D);
    for (int n = s; n <= cyc; n++) begin
      n_chk++;
      if (a_obs[n] !== pack_exp(n)) $display("FAIL update_sb cyc=%0d got=%h exp=%h", n, a_obs[n], pack_exp(n));
      else n_pass++;
    end
  endtask

  task automatic test_anim();
    int s;
    s = cyc + 1;
    do_update(100, 50, 0, 1);
    for (int f = 0; f < 34; f++) begin
      frame();
      scan(100, 50);
      n_chk++;
      if (mem_addr !== 11'(m_anim() * SW * SH)) $display("FAIL anim_base f=%0d got=%0d exp=%0d", f, mem_addr, m_anim() * SW * SH);
      else n_pass++;
      scan(101 + (f % 14), 51 + f);
    end
    do_update(100, 50, 0, 0);
    frame();
    scan(100, 50);
    n_chk++;
    if (mem_addr !== 11'd0) $display("FAIL anim_stop got=%0d exp=0", mem_addr);
    else n_pass++;
    idle(D);
    for (int n = s; n <= cyc; n++) begin
      n_chk++;
      if (a_obs[n] !== pack_exp(n)) $display("FAIL anim_sb cyc=%0d got=%h exp=%h", n, a_obs[n], pack_exp(n));
      else n_pass++;
    end
  endtask

  task automatic test_edge_clip();
    int s;
    s = cyc + 1;
    do_update(630, 470, 0, 0);
    frame();
    scan(639, 479);
    n_chk++;
    if ({mem_rd, mem_addr} !== {1'b1, 11'd153}) $display("FAIL edge_hit got=%b/%0d exp=1/153", mem_rd, mem_addr);
    else n_pass++;
    scan(0, 479); scan(639, 0); scan(629, 470);
    do_update(1020, 1020, 0, 0);
    frame();
    scan(1023, 1023);
    n_chk++;
    if ({mem_rd, mem_addr} !== {1'b1, 11'd51}) $display("FAIL max_hit got=%b/%0d exp=1/51", mem_rd, mem_addr);
    else n_pass++;
    scan(2, 1020);
    n_chk++;
    if (mem_rd !== 1'b0) $display("FAIL no_wrap_x got=%b exp=0", mem_rd);
    else n_pass++;
    scan(1020, 3);
    n_chk++;
    if (mem_rd !== 1'b0) $display("FAIL no_wrap_y got=%b exp=0", mem_rd);
    else n_pass++;
    idle(D);
    for (int n = s; n <= cyc; n++) begin
      n_chk++;
      if (a_obs[n] !== pack_exp(n)) $display("FAIL edge_sb cyc=%0d got=%h exp=%h", n, a_obs[n], pack_exp(n));
      else n_pass++;
    end
  endtask

  task automatic test_random_traffic();
    int s;
    s = cyc + 1;
    for (int i = 0; i < 900; i++) begin
      if (!upd.upd_req && $urandom_range(0, 19) == 0) begin
        upd.pos_x = 10'($urandom); upd.pos_y = 10'($urandom);
        upd.facing_left = 1'($urandom); upd.walking = ($urandom_range(0, 3) != 0);
        upd.upd_req = 1'b1;
      end
      frame_start = ($urandom_range(0, 9) == 0);
      pix_valid   = ($urandom_range(0, 3) != 0);
      DrawX = 10'(m_ax + $urandom_range(0, SW + 8) - 4);
      DrawY = 10'(m_ay + $urandom_range(0, SH + 8) - 4);
      tick();
      if (upd.upd_ack) upd.upd_req = 1'b0;
    end
    frame_start = 1'b0; upd.upd_req = 1'b0;
    idle(D + 1);
    for (int n = s; n <= cyc; n++) begin
      n_chk++;
      if (a_obs[n] !== pack_exp(n)) $display("FAIL random_sb cyc=%0d got=%h exp=%h", n, a_obs[n], pack_exp(n));
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    int s;
    s = cyc + 1;
    do_update(120, 80, 1, 1);
    frame();
    upd.pos_x = 10'd7; upd.pos_y = 10'd9; upd.upd_req = 1'b1;
    scan(121, 81);
    scan(125, 90);
    #2 Reset_n = 1'b0;
    #1;
    n_chk++;
    if (cur_obs() !== '0) $display("FAIL async_reset_now got=%h exp=0", cur_obs());
    else n_pass++;
    m_ax = 0; m_ay = 0; m_af = 0; m_aw = 0; m_px = 0; m_py = 0; m_pf = 0; m_pw = 0;
    m_pv = 0; m_walkn = 0; m_ack = 0; m_last = 0;
    for (int k = 1; k <= D; k++) begin
      e_ack[cyc+k] = 0; e_rd[cyc+k] = 0; e_addr[cyc+k] = 0;
      e_mario[cyc+k] = 0; e_pic[cyc+k] = 0; e_sync[cyc+k] = 0;
    end
    upd.upd_req = 1'b0;
    scan(121, 81);
    scan(3, 4);
    Reset_n = 1'b1;
    scan(3, 4);
    n_chk++;
    if ({mem_rd, mem_addr} !== {1'b1, 11'd67}) $display("FAIL post_reset_pos got=%b/%0d exp=1/67", mem_rd, mem_addr);
    else n_pass++;
    for (int i = 0; i < 12; i++) scan($urandom_range(0, 20), $urandom_range(0, 36));
    idle(D + 1);
    for (int n = s; n <= cyc; n++) begin
      n_chk++;
      if (a_obs[n] !== pack_exp(n)) $display("FAIL async_sb cyc=%0d got=%h exp=%h", n, a_obs[n], pack_exp(n));
      else n_pass++;
    end
  endtask

  initial begin
    upd.pos_x = '0; upd.pos_y = '0; upd.facing_left = 1'b0; upd.walking = 1'b0; upd.upd_req = 1'b0;
    for (int i = 0; i < 2048; i++)
      rom[i] = ($urandom_range(0, 7) == 0) ? KEY : 24'($urandom);
    rom[0] = 24'h0A0B0C;
    rom[5] = KEY;
    rom[6] = 24'h123456;
    test_reset();
    test_basic_hit();
    test_facing();
    test_update_timing();
    test_anim();
    test_edge_clip();
    test_random_traffic();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
